pc_seq: RTL
===========

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles spent waiting for mem_ack before faulting (range 1..255).
REQ-002 SHALL have ports: clk in 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports: run_sw in 1, panel run level; step_sw in 1, panel single-step; dep_sw in 1, panel deposit-PC-from-switches.
REQ-005 SHALL have ports: mem_ack in 1, memory read data valid; ex_done in 1, decoder finished current instruction; jmp in 1 and skip in 1, qualifiers sampled with ex_done; halt_req in 1, halt at instruction end.
REQ-006 SHALL have ports: incp_clk out 1, PC increment clock pulse; rdp out 1, PC drives address bus; nwrp out 1, active-low PC load from bus; nsw out 1, active-low PC load from switches.
REQ-007 SHALL have ports: mem_req out 1; ir_ld out 1, instruction register load strobe; running out 1; fault out 1, sticky memory timeout flag.

Function
REQ-008 SHALL implement states HALT, FETCH, INC, EXEC, JUMP, SKIP, DEP.
REQ-009 SHALL register every output, with no combinational path from input to output; incp_clk, nwrp and nsw SHALL be glitch-free.
REQ-010 SHALL detect rising edges of step_sw and dep_sw by comparing against one registered copy each; run_sw SHALL be level-sensitive.
REQ-011 HALT: if dep_sw edge, go to DEP; else if fault clear and (run_sw or step_sw edge), go to FETCH; dep_sw SHALL win when it coincides with run or step.
REQ-012 DEP: nsw=0 for exactly 2 cycles, then return to HALT; DEP SHALL be entered only from HALT, and dep_sw edges in other states SHALL be ignored.
REQ-013 FETCH: rdp=1 and mem_req=1 from the first cycle; on mem_ack, ir_ld=1 for one cycle and go to INC.
REQ-014 FETCH SHALL count wait cycles; if mem_ack is still absent after MEM_TIMEOUT cycles, set fault and go to HALT with rdp and mem_req deasserted next cycle.
REQ-015 INC: incp_clk=1 for exactly one cycle, then go to EXEC, so the PC advances once per fetch.
REQ-016 EXEC: wait indefinitely for ex_done; on ex_done, jmp goes to JUMP, else skip goes to SKIP, else go to end-of-instruction; jmp SHALL take priority over skip.
REQ-017 JUMP: nwrp=0 for exactly one cycle, with rdp=0; then go to end-of-instruction.
REQ-018 SKIP: incp_clk=1 for one cycle, then go to end-of-instruction.
REQ-019 End-of-instruction: go to FETCH if run_sw=1 and halt_req=0, else go to HALT; a step SHALL therefore execute exactly one instruction.
REQ-020 halt_req SHALL be evaluated only at end-of-instruction, never aborting FETCH, INC, EXEC, JUMP or SKIP.
REQ-021 rdp and nwrp=0 SHALL never be asserted in the same cycle; incp_clk SHALL never be high while nwrp=0 or nsw=0.
REQ-022 running SHALL be 1 in every state except HALT and DEP.
REQ-023 fault SHALL clear only on reset or a dep_sw edge.

Reset
REQ-024 rst SHALL force state HALT, clear the timeout counter, clear fault and both edge registers, and set outputs incp_clk=0, rdp=0, nwrp=1, nsw=1, mem_req=0, ir_ld=0, running=0.
REQ-025 rst asserted mid-instruction SHALL abandon it on the next edge with no further strobe issued.

Structure
REQ-026 SHALL place the state encoding typedef and the MEM_TIMEOUT default in shared package q2_ctrl_pkg.
REQ-027 SHALL use one sub-module, edge_det, instantiated for step_sw and dep_sw; the remainder is a single FSM with a wait counter.

Verification
REQ-028 SHALL cover single step: rst, then step_sw pulse, mem_ack after 3 cycles, ex_done with jmp=0 and skip=0 -> exactly one ir_ld, one incp_clk pulse, then HALT.
REQ-029 SHALL cover jump: run_sw=1, ex_done with jmp=1 and skip=1 -> nwrp low 1 cycle, no second incp_clk, next FETCH rdp=1.
REQ-030 SHALL cover skip: ex_done with skip=1 -> 2 incp_clk pulses for that instruction, separated by at least one EXEC cycle.
REQ-031 SHALL cover timeout: MEM_TIMEOUT=4 with mem_ack held 0 -> fault=1, HALT after 4 wait cycles, run_sw ignored until dep_sw edge.
REQ-032 SHALL cover deposit: dep_sw rising while halted -> nsw=0 for 2 cycles; dep_sw rising during EXEC -> no nsw activity.
REQ-033 SHALL cover halt and reset: halt_req during EXEC completes the instruction, then HALT; rst during FETCH -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/q2_ctrl_pkg.sv
// q2_ctrl_pkg: shared state encoding and timeout default for the PC sequencer
package q2_ctrl_pkg;
  typedef enum logic [2:0] {S_HALT, S_FETCH, S_INC, S_EXEC, S_JUMP, S_SKIP, S_DEP} state_t;
  localparam int MEM_TIMEOUT_DEF = 15;
endpackage

// File: rtl/edge_det.sv
// edge_det: rising-edge detector against one registered copy of the input
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);
  logic r_q;
  always_ff @(posedge clk) r_q <= rst ? 1'b0 : i_d;
  assign o_rise = i_d & ~r_q;
endmodule

// File: rtl/pc_seq.sv
// pc_seq: front-panel driven PC sequencer FSM with fetch timeout and registered strobes
module pc_seq
  import q2_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run_sw,
  input  logic step_sw,
  input  logic dep_sw,
  input  logic mem_ack,
  input  logic ex_done,
  input  logic jmp,
  input  logic skip,
  input  logic halt_req,
  output logic incp_clk,
  output logic rdp,
  output logic nwrp,
  output logic nsw,
  output logic mem_req,
  output logic ir_ld,
  output logic running,
  output logic fault
);
  state_t r_state, w_nxt, w_eoi;
  logic [7:0] r_cnt;
  logic r_fault, r_incp, r_rdp, r_nwrp, r_nsw, r_ir_ld, r_running;
  logic w_step, w_dep, w_to;
  edge_det u_step (.clk(clk), .rst(rst), .i_d(step_sw), .o_rise(w_step));
  edge_det u_dep (.clk(clk), .rst(rst), .i_d(dep_sw), .o_rise(w_dep));
  assign w_eoi = (run_sw && !halt_req) ? S_FETCH : S_HALT;
  assign w_to = (r_state == S_FETCH) && !mem_ack && (r_cnt == 8'(MEM_TIMEOUT - 1));
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_HALT:  w_nxt = w_dep ? S_DEP : (!r_fault && (run_sw || w_step)) ? S_FETCH : S_HALT;
      S_DEP:   w_nxt = (r_cnt == 8'd1) ? S_HALT : S_DEP;
      S_FETCH: w_nxt = mem_ack ? S_INC : w_to ? S_HALT : S_FETCH;
      S_INC:   w_nxt = S_EXEC;
      S_EXEC:  w_nxt = !ex_done ? S_EXEC : jmp ? S_JUMP : skip ? S_SKIP : w_eoi;
      S_JUMP:  w_nxt = w_eoi;
      S_SKIP:  w_nxt = w_eoi;
      default: w_nxt = S_HALT;
    endcase
  end
  // outputs are decoded from the next state so each flop tracks the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_HALT;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_incp    <= 1'b0;
      r_rdp     <= 1'b0;
      r_nwrp    <= 1'b1;
      r_nsw     <= 1'b1;
      r_ir_ld   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= (w_nxt == r_state) ? r_cnt + 8'd1 : 8'd0;
      r_fault   <= w_to ? 1'b1 : (r_state == S_HALT && w_dep) ? 1'b0 : r_fault;
      r_incp    <= (w_nxt == S_INC) || (w_nxt == S_SKIP);
      r_rdp     <= w_nxt == S_FETCH;
      r_nwrp    <= w_nxt != S_JUMP;
      r_nsw     <= w_nxt != S_DEP;
      r_ir_ld   <= (r_state == S_FETCH) && (w_nxt == S_INC);
      r_running <= (w_nxt != S_HALT) && (w_nxt != S_DEP);
    end
  end
  assign incp_clk = r_incp;
  assign rdp      = r_rdp;
  assign mem_req  = r_rdp;
  assign nwrp     = r_nwrp;
  assign nsw      = r_nsw;
  assign ir_ld    = r_ir_ld;
  assign running  = r_running;
  assign fault    = r_fault;
endmodule
